// File: rtl/cpu_bus_arb.sv
// Two-master bus arbiter: shares one memory bus between the CPU instruction and data ports.
// Data accesses win by default, but a waiting fetch is served after D_STREAK_MAX data grants in a row.
module cpu_bus_arb #(
    parameter int D_STREAK_MAX   = 4,
    parameter int CPU_ADDR_WIDTH = 32,
    parameter int CPU_DATA_WIDTH = 32,
    parameter int CPU_BEN_WIDTH  = 4
) (
    input  logic                      clk,
    input  logic                      nrst,
    input  logic [CPU_ADDR_WIDTH-1:0] i_IAddr,
    input  logic                      i_IRdC,
    output logic [CPU_DATA_WIDTH-1:0] o_IData,
    output logic                      o_IRdy,
    output logic                      o_IErr,
    input  logic [CPU_ADDR_WIDTH-1:0] i_DAddr,
    input  logic                      i_DCmd,
    input  logic                      i_DRnW,
    input  logic [CPU_BEN_WIDTH-1:0]  i_DBen,
    input  logic [CPU_DATA_WIDTH-1:0] i_DData,
    output logic [CPU_DATA_WIDTH-1:0] o_DData,
    output logic                      o_DRdy,
    output logic                      o_DErr,
    output logic [CPU_ADDR_WIDTH-1:0] o_MAddr,
    output logic                      o_MCmd,
    output logic                      o_MRnW,
    output logic [CPU_BEN_WIDTH-1:0]  o_MBen,
    output logic [CPU_DATA_WIDTH-1:0] o_MData,
    input  logic [CPU_DATA_WIDTH-1:0] i_MData,
    input  logic                      i_MRdy,
    input  logic                      i_MErr,
    output logic                      o_gnt_i,
    output logic                      o_gnt_d
);

    localparam int STREAK_W = $clog2(D_STREAK_MAX + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(D_STREAK_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arbState_t;

    arbState_t                 r_state;
    logic [STREAK_W-1:0]       r_dStreak;
    logic [CPU_ADDR_WIDTH-1:0] r_MAddr;
    logic                      r_MCmd;
    logic                      r_MRnW;
    logic [CPU_BEN_WIDTH-1:0]  r_MBen;
    logic [CPU_DATA_WIDTH-1:0] r_MData;

    arbState_t                 w_nextState;
    logic [STREAK_W-1:0]       w_nextStreak;
    logic [CPU_ADDR_WIDTH-1:0] w_nextMAddr;
    logic                      w_nextMCmd;
    logic                      w_nextMRnW;
    logic [CPU_BEN_WIDTH-1:0]  w_nextMBen;
    logic [CPU_DATA_WIDTH-1:0] w_nextMData;

    logic w_streakFull;
    logic w_grantD;
    logic w_gntI;
    logic w_gntD;

    assign w_streakFull = (r_dStreak == STREAK_MAX);
    // A waiting fetch blocks the data port only once the data streak has saturated.
    assign w_grantD     = i_DCmd && !(i_IRdC && w_streakFull);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state   <= IDLE;
            r_dStreak <= '0;
            r_MAddr   <= '0;
            r_MCmd    <= 1'b0;
            r_MRnW    <= 1'b0;
            r_MBen    <= '0;
            r_MData   <= '0;
        end else begin
            r_state   <= w_nextState;
            r_dStreak <= w_nextStreak;
            r_MAddr   <= w_nextMAddr;
            r_MCmd    <= w_nextMCmd;
            r_MRnW    <= w_nextMRnW;
            r_MBen    <= w_nextMBen;
            r_MData   <= w_nextMData;
        end
    end

    always_comb begin
        w_nextState  = r_state;
        w_nextStreak = r_dStreak;
        w_nextMAddr  = r_MAddr;
        w_nextMCmd   = r_MCmd;
        w_nextMRnW   = r_MRnW;
        w_nextMBen   = r_MBen;
        w_nextMData  = r_MData;
        case (r_state)
            IDLE: begin
                if (w_grantD) begin
                    w_nextState  = GNT_D;
                    w_nextMAddr  = i_DAddr;
                    w_nextMRnW   = i_DRnW;
                    w_nextMBen   = i_DBen;
                    w_nextMData  = i_DData;
                    w_nextMCmd   = 1'b1;
                    if (!i_IRdC) begin
                        w_nextStreak = '0;
                    end else if (!w_streakFull) begin
                        w_nextStreak = r_dStreak + STREAK_W'(1);
                    end
                end else if (i_IRdC) begin
                    w_nextState  = GNT_I;
                    w_nextMAddr  = i_IAddr;
                    w_nextMRnW   = 1'b1;
                    w_nextMBen   = '1;
                    w_nextMData  = '0;
                    w_nextMCmd   = 1'b1;
                    w_nextStreak = '0;
                end
            end
            GNT_I, GNT_D: begin
                if (i_MRdy) begin
                    w_nextState = IDLE;
                    w_nextMCmd  = 1'b0;
                end
            end
            default: begin
                w_nextState = IDLE;
                w_nextMCmd  = 1'b0;
            end
        endcase
    end

    assign w_gntI = (r_state == GNT_I);
    assign w_gntD = (r_state == GNT_D);

    assign o_gnt_i = w_gntI;
    assign o_gnt_d = w_gntD;
    assign o_MAddr = r_MAddr;
    assign o_MCmd  = r_MCmd;
    assign o_MRnW  = r_MRnW;
    assign o_MBen  = r_MBen;
    assign o_MData = r_MData;

    // Slave responses reach only the port that currently owns the bus.
    assign o_IRdy  = i_MRdy & w_gntI;
    assign o_IErr  = i_MErr & i_MRdy & w_gntI;
    assign o_DRdy  = i_MRdy & w_gntD;
    assign o_DErr  = i_MErr & i_MRdy & w_gntD;
    assign o_IData = i_MData;
    assign o_DData = i_MData;

endmodule

// File: doc/cpu_bus_arb.md
# cpu_bus_arb

Two-master arbiter that shares one external memory bus between the CPU instruction port (I-Port) and data port (D-Port). It sits between `cpu_top` and the system interconnect. It serialises fetches and loads/stores onto a single master port (M-Port), gives data accesses priority, and enforces a starvation bound for instruction fetches. All M-Port request outputs are registered, and responses are routed back to the granted port only.

## Interface
Parameters:
- `D_STREAK_MAX`, default 4: the maximum number of consecutive D grants allowed while an I request is waiting (≥1).

Ports. `CPU_ADDR_WIDTH` and `CPU_DATA_WIDTH` are 32; `CPU_BEN_WIDTH` is 4.
- `clk` in 1: clock.
- `nrst` in 1: reset, asynchronous, active-low.
- `i_IAddr` in ADDR: fetch address.
- `i_IRdC` in 1: fetch request.
- `o_IData` out DATA: fetch data.
- `o_IRdy` out 1: fetch done.
- `o_IErr` out 1: fetch bus error.
- `i_DAddr` in ADDR: data address.
- `i_DCmd` in 1: data request.
- `i_DRnW` in 1: data direction; 1 = read.
- `i_DBen` in BEN: byte enables.
- `i_DData` in DATA: write data.
- `o_DData` out DATA: read data.
- `o_DRdy` out 1: data done.
- `o_DErr` out 1: data bus error.
- `o_MAddr` out ADDR: bus address.
- `o_MCmd` out 1: bus request.
- `o_MRnW` out 1: bus direction.
- `o_MBen` out BEN: bus byte enables.
- `o_MData` out DATA: bus write data.
- `i_MData` in DATA: bus read data.
- `i_MRdy` in 1: bus transfer done.
- `i_MErr` in 1: bus error.
- `o_gnt_i` out 1: I-Port owns the bus.
- `o_gnt_d` out 1: D-Port owns the bus.

## Operation
- States:
  - IDLE: no owner.
  - GNT_I: instruction fetch in flight.
  - GNT_D: data access in flight.
- Reset value of every output: `o_MCmd`, `o_MRnW`, `o_MAddr`, `o_MBen`, `o_MData` = 0; `o_gnt_i`, `o_gnt_d` = 0. State = IDLE, `d_streak` = 0.
- Arbitration happens only in IDLE, on the requests present in that cycle:
  - `i_DCmd` && !(`i_IRdC` && `d_streak`==`D_STREAK_MAX`) → GNT_D.
  - Otherwise, `i_IRdC` → GNT_I.
  - Otherwise, remain in IDLE.
- Grant latching:
  - On a D grant, latch `o_MAddr`=`i_DAddr`, `o_MRnW`=`i_DRnW`, `o_MBen`=`i_DBen`, `o_MData`=`i_DData`, and set `o_MCmd`=1.
  - On an I grant, latch `o_MAddr`=`i_IAddr`, `o_MRnW`=1, `o_MBen`=4'b1111, `o_MData`=0, and set `o_MCmd`=1.
- `d_streak` update, at grant time only:
  - D granted while `i_IRdC`=1 → increment, saturating at `D_STREAK_MAX`.
  - I granted, or D granted with `i_IRdC`=0 → clear to 0.
- Completion: in a GNT state, a cycle with `i_MRdy`=1 ends the transfer.
  - `i_MErr` is meaningful only together with `i_MRdy`.
  - `i_MErr` without `i_MRdy` is ignored.
  - The next state is IDLE, `o_MCmd` clears, and the grant outputs clear.
- Response routing is combinational from M-Port inputs, gated by state:
  - `o_IRdy` = `i_MRdy` & GNT_I; `o_IErr` = `i_MErr` & `i_MRdy` & GNT_I.
  - `o_DRdy` and `o_DErr` follow the same pattern with GNT_D.
  - `o_IData` and `o_DData` = `i_MData` (unconditional; valid only with the matching Rdy).
- The non-granted port never sees Rdy or Err.
- Latched request fields stay stable for the whole transfer. Changes or withdrawal of the owning port's request inputs mid-transfer are ignored: the transfer completes and Rdy/Err are still forwarded.
- Asynchronous reset mid-transfer: all outputs and state are forced to reset values immediately. The outstanding slave response is not forwarded.

## Timing
- Request first seen in IDLE at cycle N → `o_MCmd`=1 and fields valid from cycle N+1.
- Earliest `i_MRdy` is at N+1, giving `o_IRdy`/`o_DRdy` in that same cycle. The minimum master-to-done latency is therefore 1 cycle plus slave wait states.
- `i_MRdy` at cycle K → IDLE at K+1, with `o_MCmd`=0 at K+1. Arbitration at K+1 uses the requests present at K+1 (the master's next request). A new grant issues at K+2.
- Peak throughput: 1 transfer per 2 cycles with a zero-wait slave.
- `o_MCmd` is never high for 2 consecutive transfers without an intervening low cycle.
- With both ports requesting continuously: exactly `D_STREAK_MAX` D transfers, then 1 I transfer, then repeat.

## Test plan
- I only: `i_IRdC`=1, `i_IAddr`=0x1000, slave returns 0xDEADBEEF with 2 wait states → `o_MCmd` rises one cycle after the request, `o_MAddr`=0x1000, `o_MRnW`=1, `o_MBen`=0xF. `o_IRdy` pulses with `o_IData`=0xDEADBEEF; `o_DRdy` stays 0.
- D write: `i_DAddr`=0x2004, `i_DRnW`=0, `i_DBen`=0x3, `i_DData`=0x1234 → M-Port carries exactly these fields. `o_DRdy` pulses once and `o_MCmd`=0 the following cycle.
- Simultaneous requests in IDLE with `d_streak`=0 → D granted first. With both held and `D_STREAK_MAX`=4, the grant sequence is D,D,D,D,I,D,D,D,D,I.
- Error: I fetch with `i_MRdy`=`i_MErr`=1 → `o_IErr`=1 and `o_IRdy`=1 for one cycle; `o_DErr`=0. `i_MErr`=1 without Rdy has no effect.
- Request field change mid-transfer: `i_DAddr` changes from 0x10 to 0x20 while in GNT_D → `o_MAddr` stays 0x10 until Rdy.
- `nrst` low during GNT_D with a pending slave → all outputs 0 immediately. After release, with no requests, the block stays in IDLE and a late `i_MRdy` produces no `o_DRdy`.
